// File: rtl/neurocore_pkg.sv
// Shared types and constants for the neural core's pin-level front ends.
package neurocore_pkg;

   localparam int unsigned UART_CLKS_PER_BIT = 87;
   localparam int unsigned UART_DATA_BITS    = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin, with a configurable reset value.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_meta <= RESET_VAL;
         o_q    <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         o_q    <= r_meta;
      end
   end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchronised RXD, mid-bit sampling FSM and a one-entry
// valid/ready holding register with framing-error and overrun pulses.
module uart_rx_frontend
   import neurocore_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_rxd,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic       o_frame_err,
   output logic       o_overrun,
   output logic       o_busy
);

   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
   localparam int unsigned TMR_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W    = 3;

   logic           w_rxd_s;
   logic           w_half_done;
   logic           w_bit_done;
   uart_rx_state_e r_state;
   logic [TMR_W-1:0] r_timer;
   logic [IDX_W-1:0] r_bit_idx;
   logic [7:0]     r_shift;
   logic           r_commit;
   logic           r_ferr_pend;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_rxd_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_rxd),
      .o_q     (w_rxd_s)
   );

   assign w_half_done = (r_timer == TMR_W'(HALF_BIT - 1));
   assign w_bit_done  = (r_timer == TMR_W'(CLKS_PER_BIT - 1));

   // Frame decoder; commit and error are staged one cycle so both land with RX_VALID timing.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_timer     <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_commit    <= 1'b0;
         r_ferr_pend <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         r_commit    <= 1'b0;
         r_ferr_pend <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_rxd_s) begin
                  r_state   <= START;
                  r_timer   <= '0;
                  r_bit_idx <= '0;
                  o_busy    <= 1'b1;
               end
            end
            START: begin
               if (w_half_done) begin
                  r_timer <= '0;
                  if (w_rxd_s) begin
                     r_state <= IDLE;
                     o_busy  <= 1'b0;
                  end else begin
                     r_state <= DATA;
                  end
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            DATA: begin
               if (w_bit_done) begin
                  r_timer <= '0;
                  r_shift <= {w_rxd_s, r_shift[7:1]};
                  if (r_bit_idx == IDX_W'(UART_DATA_BITS - 1)) begin
                     r_state <= STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                  end
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            STOP: begin
               if (w_bit_done) begin
                  r_timer <= '0;
                  if (w_rxd_s) begin
                     r_commit <= 1'b1;
                     r_state  <= IDLE;
                     o_busy   <= 1'b0;
                  end else begin
                     r_ferr_pend <= 1'b1;
                     r_state     <= BREAK;
                  end
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            BREAK: begin
               if (w_rxd_s) begin
                  r_state <= IDLE;
                  o_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Holding register: a commit into a full, unconsumed slot is dropped and flagged.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_rx_data   <= '0;
         o_rx_valid  <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= r_ferr_pend;
         o_overrun   <= 1'b0;
         if (r_commit) begin
            if (!o_rx_valid || i_rx_ready) begin
               o_rx_data  <= r_shift;
               o_rx_valid <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Randomised and directed bench for uart_rx_frontend against a frame-level model.
module tb_uart_rx_frontend;

   localparam int CPB   = 8;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       i_reset;
   logic       i_rxd;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic       i_rx_ready;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] mon_q[$];
   logic [7:0] exp_q[$];
   int mon_ferr = 0;
   int mon_ovr  = 0;
   int mon_both = 0;
   int exp_ferr = 0;
   int exp_ovr  = 0;

   uart_rx_frontend #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_rxd       (i_rxd),
      .o_rx_data   (o_rx_data),
      .o_rx_valid  (o_rx_valid),
      .i_rx_ready  (i_rx_ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   // Observe accepted bytes and flag pulses away from the active edge.
   always @(negedge clk) begin
      if (o_rx_valid === 1'b1 && i_rx_ready === 1'b1) mon_q.push_back(o_rx_data);
      if (o_frame_err === 1'b1) mon_ferr++;
      if (o_overrun === 1'b1) mon_ovr++;
      if (o_frame_err === 1'b1 && o_overrun === 1'b1) mon_both++;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      i_rxd = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame; cycle 0 is the first edge that samples the start bit.
   // Returns #1 after edge FRAME-1, where the result of the frame must be visible.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int abort_at, input bit chk_lat);
      logic [9:0] bits;
      bits = {stop_bit, b, 1'b0};
      for (int c = 0; c < FRAME; c++) begin
         i_rxd = bits[c / CPB];
         @(posedge clk);
         #1;
         if (c == abort_at) begin
            i_reset = 1'b1;
            i_rxd   = 1'b1;
            @(posedge clk);
            #1;
            i_reset = 1'b0;
            return;
         end
         if (chk_lat && c == FRAME - 2) chk_eq("valid_before_latency", 32'(o_rx_valid), 32'd0);
      end
      i_rxd = 1'b1;
   endtask

   task automatic frame_end_chk(input string tag, input logic [7:0] b, input logic stop_bit);
      chk_eq({tag, "_valid"}, 32'(o_rx_valid), 32'(stop_bit));
      if (stop_bit) chk_eq({tag, "_data"}, 32'(o_rx_data), 32'(b));
      chk_eq({tag, "_frame_err"}, 32'(o_frame_err), 32'(!stop_bit));
      chk_eq({tag, "_overrun"}, 32'(o_overrun), 32'd0);
   endtask

   initial begin
      int f0;
      int q0;
      logic [7:0] rb;
      logic       rs;
      int         gap;

      i_reset    = 1'b1;
      i_rxd      = 1'b1;
      i_rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_valid", 32'(o_rx_valid), 32'd0);
      chk_eq("rst_data", 32'(o_rx_data), 32'd0);
      chk_eq("rst_frame_err", 32'(o_frame_err), 32'd0);
      chk_eq("rst_overrun", 32'(o_overrun), 32'd0);
      chk_eq("rst_busy", 32'(o_busy), 32'd0);
      i_reset = 1'b0;
      idle(5);

      // Single byte, exact latency and one-cycle VALID pulse
      send_frame(8'hA5, 1'b1, -1, 1'b1);
      frame_end_chk("a5", 8'hA5, 1'b1);
      exp_q.push_back(8'hA5);
      @(posedge clk);
      #1;
      chk_eq("a5_pulse_end", 32'(o_rx_valid), 32'd0);
      idle(10);

      // Back-to-back frames with no idle gap
      send_frame(8'h00, 1'b1, -1, 1'b1);
      frame_end_chk("b2b0", 8'h00, 1'b1);
      exp_q.push_back(8'h00);
      send_frame(8'hFF, 1'b1, -1, 1'b1);
      frame_end_chk("b2b1", 8'hFF, 1'b1);
      exp_q.push_back(8'hFF);
      idle(10);

      // Three-cycle glitch is rejected at the start-bit mid sample
      f0 = mon_ferr;
      q0 = mon_q.size();
      i_rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("glitch_busy_high", 32'(o_busy), 32'd1);
      i_rxd = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk_eq("glitch_busy_low", 32'(o_busy), 32'd0);
      idle(20);
      chk_eq("glitch_no_ferr", 32'(mon_ferr - f0), 32'd0);
      chk_eq("glitch_no_valid", 32'(mon_q.size() - q0), 32'd0);

      // Bad stop bit followed by a held-low break line
      f0 = mon_ferr;
      q0 = mon_q.size();
      send_frame(8'h3C, 1'b0, -1, 1'b1);
      frame_end_chk("brk", 8'h3C, 1'b0);
      exp_ferr++;
      i_rxd = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      chk_eq("brk_busy_held", 32'(o_busy), 32'd1);
      chk_eq("brk_single_ferr", 32'(mon_ferr - f0), 32'd1);
      chk_eq("brk_no_valid", 32'(mon_q.size() - q0), 32'd0);
      i_rxd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_eq("brk_busy_until_sync", 32'(o_busy), 32'd1);
      @(posedge clk);
      #1;
      chk_eq("brk_busy_released", 32'(o_busy), 32'd0);
      idle(10);

      // Overrun: consumer stalled across two commits
      i_rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, -1, 1'b1);
      frame_end_chk("ovr_first", 8'h11, 1'b1);
      send_frame(8'h22, 1'b1, -1, 1'b0);
      chk_eq("ovr_pulse", 32'(o_overrun), 32'd1);
      chk_eq("ovr_valid_held", 32'(o_rx_valid), 32'd1);
      chk_eq("ovr_data_held", 32'(o_rx_data), 32'h11);
      chk_eq("ovr_no_ferr", 32'(o_frame_err), 32'd0);
      exp_ovr++;
      @(posedge clk);
      #1;
      chk_eq("ovr_pulse_end", 32'(o_overrun), 32'd0);
      chk_eq("ovr_still_valid", 32'(o_rx_valid), 32'd1);
      i_rx_ready = 1'b1;
      exp_q.push_back(8'h11);
      @(posedge clk);
      #1;
      chk_eq("ovr_consumed", 32'(o_rx_valid), 32'd0);
      chk_eq("ovr_data_kept", 32'(o_rx_data), 32'h11);
      idle(10);

      // Reset in the middle of data bit 4 aborts silently
      f0 = mon_ferr;
      q0 = mon_q.size();
      send_frame(8'h5A, 1'b1, 5 * CPB + 3, 1'b0);
      chk_eq("midrst_valid", 32'(o_rx_valid), 32'd0);
      chk_eq("midrst_data", 32'(o_rx_data), 32'd0);
      chk_eq("midrst_busy", 32'(o_busy), 32'd0);
      chk_eq("midrst_ferr", 32'(o_frame_err), 32'd0);
      idle(3 * FRAME);
      chk_eq("midrst_no_ferr", 32'(mon_ferr - f0), 32'd0);
      chk_eq("midrst_no_valid", 32'(mon_q.size() - q0), 32'd0);
      send_frame(8'h5A, 1'b1, -1, 1'b1);
      frame_end_chk("postrst", 8'h5A, 1'b1);
      exp_q.push_back(8'h5A);
      idle(10);

      // Random frames with occasional bad stop bits and random gaps
      for (int n = 0; n < 24; n++) begin
         rb  = 8'($urandom);
         rs  = ($urandom_range(0, 4) != 0);
         gap = rs ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 16));
         send_frame(rb, rs, -1, 1'b1);
         frame_end_chk("rnd", rb, rs);
         if (rs) exp_q.push_back(rb);
         else exp_ferr++;
         idle(gap);
      end
      idle(20);

      chk_eq("total_bytes", 32'(mon_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
         chk_eq("byte_stream", 32'(mon_q[i]), 32'(exp_q[i]));
      chk_eq("total_frame_err", 32'(mon_ferr), 32'(exp_ferr));
      chk_eq("total_overrun", 32'(mon_ovr), 32'(exp_ovr));
      chk_eq("ferr_ovr_exclusive", 32'(mon_both), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
Serial receive front end feeding the neural core's command/operand path. Synchronises the raw RXD pin and decodes 8N1 UART frames, LSB first. Presents each good byte through a one-entry valid/ready holding register. Reports framing errors and overruns as single-cycle pulses.

Parameters:
CLKS_PER_BIT, 87, system clocks per UART bit (10 MHz / 115200); must be >= 4
HALF_BIT, CLKS_PER_BIT/2, clocks from detected start edge to the start-bit mid-sample (derived, not overridden)

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous, active-high reset
RXD  input  1  raw asynchronous serial line, idle high
RX_DATA  output  8  received byte, stable while RX_VALID=1
RX_VALID  output  1  holding register full
RX_READY  input  1  consumer accepts byte when RX_VALID & RX_READY on a rising edge
FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low
OVERRUN  output  1  one-cycle pulse: good byte dropped because holding register full
BUSY  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (synchronous, RESET=1 at a rising edge): FSM=IDLE, counters 0, synchroniser flops=1, RX_DATA=0x00, RX_VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0. Reset mid-frame aborts the frame silently; no partial byte or error is reported.
- Synchroniser: two flops, reset to 1. rxd_s is RXD delayed 2 cycles. All decoding uses rxd_s only.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: rxd_s=0 -> START, bit counter cleared.
- START: count HALF_BIT cycles, then sample. Sample 1 -> IDLE (glitch rejected, no flag). Sample 0 -> DATA.
- DATA: sample every CLKS_PER_BIT cycles. Shift sample into bit 7 of shift register (LSB-first). After 8th sample -> STOP.
- STOP: sample after CLKS_PER_BIT cycles.
  - Sample 1 -> frame good, commit byte, -> IDLE.
  - Sample 0 -> FRAME_ERR pulse next cycle, byte discarded, -> BREAK.
- BREAK: wait for rxd_s=1, then -> IDLE. A held-low line (break) produces exactly one FRAME_ERR and no further frames.
- Commit timing: RX_VALID rises the cycle after the stop sample. Total latency from RXD falling edge to RX_VALID high = 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles; with CLKS_PER_BIT=8 this is 79.
- Holding register handshake:
  - VALID & READY: RX_VALID clears next cycle unless a commit occurs the same cycle.
  - Commit while RX_VALID=0: load byte, RX_VALID=1.
  - Commit while RX_VALID=1 & RX_READY=1: old byte consumed, new byte loaded, RX_VALID stays 1, no OVERRUN.
  - Commit while RX_VALID=1 & RX_READY=0: new byte dropped, old byte and RX_VALID held, OVERRUN pulses one cycle.
- RX_DATA changes only on commit; not cleared on consume.
- Counters: bit-timer width $clog2(CLKS_PER_BIT); bit index 3 bits, saturates, no wrap.
- FRAME_ERR and OVERRUN are never high in the same cycle; both are registered outputs.

Decomposition:
- Shared package `neurocore_pkg`: state enum {IDLE, START, DATA, STOP, BREAK}, default CLKS_PER_BIT constant, UART_DATA_BITS=8.
- One sub-module `sync_2ff`: 2-flop synchroniser with reset value parameter, reused by other pin inputs.
- FSM, timer and holding register stay in uart_rx_frontend.

Test Plan:
- CLKS_PER_BIT=8, send 0xA5 with RX_READY=1 -> RX_VALID high 79 cycles after start edge, for 1 cycle; RX_DATA=0xA5; no flags.
- Back-to-back 0x00 then 0xFF, no idle gap, RX_READY=1 -> two VALID pulses 80 cycles apart, data 0x00 then 0xFF.
- 3-cycle low glitch on idle RXD -> BUSY high briefly, then IDLE; no RX_VALID, no FRAME_ERR.
- Frame 0x3C with stop bit 0, then RXD held low 300 cycles -> single FRAME_ERR pulse, no RX_VALID, BUSY stays high until RXD returns to 1.
- RX_READY=0, send 0x11 then 0x22 -> RX_VALID=1, RX_DATA=0x11, one OVERRUN pulse at second commit; raise RX_READY -> RX_VALID clears next cycle.
- Assert RESET during DATA bit 4 of 0x5A -> all outputs reset next cycle, FSM IDLE, no VALID or FRAME_ERR; following 0x5A is received correctly.
